instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the decode-stage field splitter. Takes decoded fields (opcode, func3, func7, register addresses, immediate, format tag) over a valid/ready handshake.
- Packs them into a 32-bit RV32I instruction word and writes it into instruction memory at an auto-incrementing word address.
- Used by the test/boot path to load programs into IMEM before the core is released from reset.

Parameters:
- ADD_WIDTH, 5, register address width (rs1/rs2/rd).
- DATA_WIDTH, 32, instruction word width; only 32 is supported.
- IMEM_AW, 8, IMEM word-address width; capacity is 2**IMEM_AW words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new load at address 0.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block accepts a bundle this cycle.
- in_last  input  1  marks the final bundle of the program.
- fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode  input  7  opcode field.
- func3  input  3  funct3 field.
- func7  input  7  funct7 field.
- add_rs1  input  ADD_WIDTH  source register 1.
- add_rs2  input  ADD_WIDTH  source register 2.
- add_rd  input  ADD_WIDTH  destination register.
- imm_value  input  32  sign-extended immediate; B and J are byte offsets.
- imem_we  output  1  IMEM write strobe.
- imem_addr  output  IMEM_AW  IMEM word address.
- imem_wdata  output  DATA_WIDTH  encoded instruction.
- word_count  output  IMEM_AW+1  words written since start.
- load_done  output  1  high in DONE state.
- overflow  output  1  sticky; a bundle was rejected because IMEM is full.
- err_fmt  output  1  sticky; an illegal fmt was received.

Behaviour:
- Reset: state=IDLE; in_ready, imem_we, load_done, overflow, err_fmt = 0; imem_addr, imem_wdata, word_count = 0.
- State IDLE: in_ready=0. start -> LOAD; pointer and word_count cleared; sticky flags cleared.
- State LOAD: in_ready=1.
  - Handshake: a transfer occurs when in_valid && in_ready.
  - A bundle accepted at edge N produces imem_we=1 with registered addr/wdata in cycle N+1. Latency is 1; throughput is 1 word/cycle.
  - After each transfer: pointer+1, word_count+1.
  - Accepted with in_last=1 -> DONE.
  - Accepted into address 2**IMEM_AW-1 with in_last=0 -> FULL.
- State FULL: in_ready=0. A bundle presented with in_valid=1 sets overflow. start -> LOAD (restart).
- State DONE: load_done=1, in_ready=0. start -> LOAD (restart); word_count is held until then.
- start while in LOAD restarts: pointer and word_count go to 0, and any bundle presented that same cycle is dropped. start has priority.
- Encoding, with rd/rs1/rs2 zero-extended to 5 bits:
  - R: {func7, rs2, rs1, func3, rd, opcode}.
  - I: {imm[11:0], rs1, func3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Illegal fmt: write NOP 32'h00000013 to the current address (word still counted) and set err_fmt.
- Async reset mid-load: outputs go to reset values immediately; a write in flight is lost.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: adds sticky output err_imm (1 bit), cleared by start. It is set when:
  - I or S imm is outside [-2048, 2047];
  - B imm is outside [-4096, 4094] or imm[0]=1;
  - J imm is outside [-2**20, 2**20-2] or imm[0]=1;
  - U imm[11:0] != 0.
  The word is still written, truncated as above.
- Undefined: no err_imm port; no checking logic.

Decomposition:
- Package riscv_enc_pkg holds:
  - fmt enum (FMT_R..FMT_J);
  - FSM state enum;
  - localparam NOP_INSTR = 32'h00000013;
  - opcode constants OP_RTYPE = 7'b0110011, OP_ITYPE = 7'b0010011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011.
- One natural sub-module: instr_pack, purely combinational (fields + fmt -> word, illegal flag). It is reusable by benches as a reference model.
- FSM, pointer and output register stay in the top module.

Test Plan:
- R-type: start; fmt=0, opcode=0x33, func3=0, func7=0, rs1=1, rs2=2, rd=3, last=1 -> next cycle imem_we=1, addr=0, wdata=32'h002081B3; then load_done=1, word_count=1.
- I-type then S-type back-to-back:
  - addi x5,x0,-1 (imm=-1, opcode 0x13, rd=5) -> addr 0, wdata 32'hFFF00293.
  - sw x2,8(x1) (fmt=2, func3=2, opcode 0x23) -> addr 1, wdata 32'h0020A423; no bubble between the writes.
- B-type: beq x1,x2,+8 (fmt=3, opcode 0x63) -> 32'h00208463.
- Capacity: IMEM_AW=2; 5 bundles, none last -> addrs 0..3 written, FULL, in_ready=0; 5th stays pending and overflow=1.
- Illegal fmt=7 -> wdata 32'h00000013 written, err_fmt=1; a later start clears err_fmt and resets addr to 0.
- Reset mid-load: assert rst between two accepted bundles -> imem_we=0 and word_count=0 asynchronously; state IDLE with in_ready=0 after release.

Source files
------------

// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RV32I field encoder / IMEM loader.
// Formats, loader FSM states, canonical NOP and a few base opcodes.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Codes 6 and 7 have no instruction layout.
  function automatic logic is_legal_fmt(input logic [2:0] f);
    return (f <= FMT_J);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Decoded-field bundle with valid/ready handshake feeding the loader.
// The producer drives the master modport; the loader is the slave.
interface instr_encoder_loader_if #(
  parameter int ADD_WIDTH = 5
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [2:0]           fmt;
  logic [6:0]           opcode;
  logic [2:0]           func3;
  logic [6:0]           func7;
  logic [ADD_WIDTH-1:0] add_rs1;
  logic [ADD_WIDTH-1:0] add_rs2;
  logic [ADD_WIDTH-1:0] add_rd;
  logic [31:0]          imm_value;

  modport master (
    output in_valid, in_last, fmt, opcode, func3, func7,
           add_rs1, add_rs2, add_rd, imm_value,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, fmt, opcode, func3, func7,
           add_rs1, add_rs2, add_rd, imm_value,
    output in_ready
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I packer: decoded fields + format -> 32-bit word.
// Optional IMM_RANGE_CHECK_EN adds o_imm_err for immediates that do not fit.
module instr_pack
  import riscv_enc_pkg::*;
#(
  parameter int ADD_WIDTH = 5
) (
  input  logic [2:0]           i_fmt,
  input  logic [6:0]           i_opcode,
  input  logic [2:0]           i_func3,
  input  logic [6:0]           i_func7,
  input  logic [ADD_WIDTH-1:0] i_rs1,
  input  logic [ADD_WIDTH-1:0] i_rs2,
  input  logic [ADD_WIDTH-1:0] i_rd,
  input  logic [31:0]          i_imm,
  output logic [31:0]          o_word,
  output logic                 o_illegal
`ifdef IMM_RANGE_CHECK_EN
  ,
  output logic                 o_imm_err
`endif
);

  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;

  assign w_rs1 = 5'(i_rs1);
  assign w_rs2 = 5'(i_rs2);
  assign w_rd  = 5'(i_rd);

  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    o_word    = NOP_INSTR;
    o_illegal = 1'b0;
    case (i_fmt)
      FMT_R: o_word = {i_func7, w_rs2, w_rs1, i_func3, w_rd, i_opcode};
      FMT_I: o_word = {i_imm[11:0], w_rs1, i_func3, w_rd, i_opcode};
      FMT_S: o_word = {i_imm[11:5], w_rs2, w_rs1, i_func3, i_imm[4:0], i_opcode};
      FMT_B: o_word = {i_imm[12], i_imm[10:5], w_rs2, w_rs1, i_func3,
                       i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: o_word = {i_imm[31:12], w_rd, i_opcode};
      FMT_J: o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                       w_rd, i_opcode};
      default: o_illegal = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] w_simm;
  assign w_simm = $signed(i_imm);

  // Word is still written truncated; this only flags the lost bits.
  always_comb begin
    o_imm_err = 1'b0;
    case (i_fmt)
      FMT_I, FMT_S:
        o_imm_err = (w_simm < -32'sd2048) || (w_simm > 32'sd2047);
      FMT_B:
        o_imm_err = (w_simm < -32'sd4096) || (w_simm > 32'sd4094) || i_imm[0];
      FMT_J:
        o_imm_err = (w_simm < -32'sd1048576) || (w_simm > 32'sd1048574) || i_imm[0];
      FMT_U:
        o_imm_err = |i_imm[11:0];
      default: o_imm_err = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes decoded field bundles into RV32I words and streams them into IMEM.
// Optional feature macro: IMM_RANGE_CHECK_EN (adds sticky err_imm output).
module instr_encoder_loader
  import riscv_enc_pkg::*;
#(
  parameter int ADD_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_AW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic                  imem_we,
  output logic [IMEM_AW-1:0]    imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic [IMEM_AW:0]      word_count,
  output logic                  load_done,
  output logic                  overflow,
  output logic                  err_fmt
`ifdef IMM_RANGE_CHECK_EN
  ,
  output logic                  err_imm
`endif
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [IMEM_AW-1:0]    r_ptr;
  logic [IMEM_AW:0]      r_count;
  logic                  r_we;
  logic [IMEM_AW-1:0]    r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_overflow;
  logic                  r_err_fmt;

  logic                  w_xfer;
  logic [31:0]           w_word;
  logic                  w_illegal;

  // start outranks a bundle presented in the same cycle: that bundle is dropped.
  assign bus.in_ready = (r_state == ST_LOAD);
  assign w_xfer       = bus.in_valid && bus.in_ready && !start;

`ifdef IMM_RANGE_CHECK_EN
  logic w_imm_err;
  logic r_err_imm;
`endif

  instr_pack #(
    .ADD_WIDTH (ADD_WIDTH)
  ) u_pack (
    .i_fmt     (bus.fmt),
    .i_opcode  (bus.opcode),
    .i_func3   (bus.func3),
    .i_func7   (bus.func7),
    .i_rs1     (bus.add_rs1),
    .i_rs2     (bus.add_rs2),
    .i_rd      (bus.add_rd),
    .i_imm     (bus.imm_value),
    .o_word    (w_word),
    .o_illegal (w_illegal)
`ifdef IMM_RANGE_CHECK_EN
    ,
    .o_imm_err (w_imm_err)
`endif
  );

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_xfer) begin
            if (bus.in_last)  w_state_nxt = ST_DONE;
            else if (&r_ptr)  w_state_nxt = ST_FULL;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_count    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_overflow <= 1'b0;
      r_err_fmt  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      r_state <= w_state_nxt;
      r_we    <= w_xfer;
      if (start) begin
        r_ptr      <= '0;
        r_count    <= '0;
        r_addr     <= '0;
        r_overflow <= 1'b0;
        r_err_fmt  <= 1'b0;
      end else begin
        if (w_xfer) begin
          r_ptr     <= r_ptr + 1'b1;
          r_count   <= r_count + 1'b1;
          r_addr    <= r_ptr;
          r_wdata   <= DATA_WIDTH'(w_word);
          r_err_fmt <= r_err_fmt | w_illegal;
        end
        if ((r_state == ST_FULL) && bus.in_valid) r_overflow <= 1'b1;
      end
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_err_imm <= 1'b0;
    else if (start)  r_err_imm <= 1'b0;
    else if (w_xfer) r_err_imm <= r_err_imm | w_imm_err;
  end

  assign err_imm = r_err_imm;
`endif

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign word_count = r_count;
  assign load_done  = (r_state == ST_DONE);
  assign overflow   = r_overflow;
  assign err_fmt    = r_err_fmt;

endmodule
